matmul_sequencer: RTL

Programmable-size sequencer for the MAC-based matrix unit. It computes R = A*B + C for square N x N matrices, where N is 1..2^DIM_WIDTH and is selected per run. It walks row/col/k loop counters to produce ROM A/B/C and result-RAM addresses and the MAC strobes, with start/busy/done handshake, a stall input and a cycle counter. It sits between the host/top-level control and the MAC datapath plus memories.

---
 rtl/matmul_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: row/col/k loop sequencer for R = A*B + C on an N x N MAC matrix unit,
// producing ROM/RAM addresses, MAC strobes, start/busy/done handshake and a busy-cycle counter.
module matmul_sequencer #(
    parameter int DIM_WIDTH  = 3,
    parameter int ADDR_WIDTH = 7,
    parameter int PIPE_LAT   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  dim_m1,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [ADDR_WIDTH-1:0] b_addr,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  mac_mult,
    output logic                  mac_add_c,
    output logic                  mac_clear,
    output logic                  r_we,
    output logic [23:0]           cycle_count
);
    localparam int LW = PIPE_LAT > 1 ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {IDLE, MULT, DRAIN, ADDC, WRITE, CLEAR, DONE} state_t;

    state_t state, nxt;
    logic [DIM_WIDTH-1:0] row, col, k, n_m1;
    logic [LW-1:0] drain;
    logic [ADDR_WIDTH-1:0] n, rw, cl, kk;
    logic last_k, last_drain, last_elem, stall;

    assign busy       = state != IDLE;
    assign stall      = busy && hold;
    assign last_k     = k == n_m1;
    assign last_drain = drain == LW'(PIPE_LAT - 1);
    assign last_elem  = row == n_m1 && col == n_m1;

    assign mac_mult  = state == MULT && !hold;
    assign mac_add_c = state == ADDC && !hold;
    assign r_we      = state == WRITE && !hold;
    assign mac_clear = state == CLEAR && !hold;
    assign done      = state == DONE && !hold;

    // Counters are zero whenever the sequencer is idle, so addresses read 0 there.
    assign n  = ADDR_WIDTH'(n_m1) + 1'b1;
    assign rw = ADDR_WIDTH'(row);
    assign cl = ADDR_WIDTH'(col);
    assign kk = ADDR_WIDTH'(k);
    assign a_addr = rw * n + kk;
    assign b_addr = kk * n + cl;
    assign c_addr = rw * n + cl;
    assign r_addr = rw * n + cl;

    always_ff @(posedge clock)
        state <= reset ? IDLE : nxt;

    always_comb begin
        nxt = state;
        if (!stall)
            case (state)
                IDLE:    nxt = start ? MULT : IDLE;
                MULT:    nxt = last_k ? (PIPE_LAT == 0 ? ADDC : DRAIN) : MULT;
                DRAIN:   nxt = last_drain ? ADDC : DRAIN;
                ADDC:    nxt = WRITE;
                WRITE:   nxt = last_elem ? DONE : CLEAR;
                CLEAR:   nxt = MULT;
                DONE:    nxt = IDLE;
                default: nxt = IDLE;
            endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row         <= '0;
            col         <= '0;
            k           <= '0;
            n_m1        <= '0;
            drain       <= '0;
            cycle_count <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                n_m1        <= dim_m1;
                row         <= '0;
                col         <= '0;
                k           <= '0;
                drain       <= '0;
                cycle_count <= '0;
            end
        end else begin
            if (cycle_count != '1)
                cycle_count <= cycle_count + 24'd1;
            if (!hold)
                case (state)
                    MULT:  k <= last_k ? '0 : k + 1'b1;
                    DRAIN: drain <= last_drain ? '0 : drain + 1'b1;
                    CLEAR: begin
                        col <= col == n_m1 ? '0 : col + 1'b1;
                        if (col == n_m1)
                            row <= row + 1'b1;
                    end
                    DONE: begin
                        row <= '0;
                        col <= '0;
                    end
                    default: ;
                endcase
        end
    end
endmodule
